// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: pops narrow words and packs RATIO of
// them into one wide beat on a valid/ready stream, with flush/timeout for partials.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DSIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  logic                   run_reg;
  logic [CW-1:0]          acc_cnt_reg;
  logic [CW-1:0]          acc_cnt_next;
  logic [DSIZE-1:0]       acc_reg [RATIO];
  logic                   flush_pend_reg;
  logic                   flush_pend_next;
  logic [IW-1:0]          idle_reg;
  logic                   out_valid_reg;
  logic [DSIZE*RATIO-1:0] out_data_reg;
  logic [RATIO-1:0]       out_keep_reg;

  logic                   acc_full;
  logic                   acc_empty;
  logic                   out_free;
  logic                   pop;
  logic                   timeout_hit;
  logic                   flush_cond;
  logic                   complete;
  logic                   load;
  logic [CW-1:0]          load_n;
  logic                   acc_we;
  logic [CW-1:0]          acc_widx;
  logic [DSIZE*RATIO-1:0] load_word;
  logic [RATIO-1:0]       load_keep;

  assign acc_full  = (acc_cnt_reg == FULL_CNT);
  assign acc_empty = (acc_cnt_reg == '0);
  assign out_free  = ~out_valid_reg | out_ready;

  // A full accumulator may only accept a word when it is being unloaded this edge.
  assign pop  = run_reg & ~rempty & (~acc_full | out_free);
  assign rinc = pop;

  assign flush_cond = flush | flush_pend_reg | timeout_hit;
  assign complete   = acc_full | ((acc_cnt_reg == LAST_CNT) & pop);
  assign load       = out_free & (complete | (flush_cond & ~acc_empty));

  // When the beat comes from a full accumulator, a concurrent pop starts the
  // next accumulation; otherwise the popped word rides along in this beat.
  assign load_n   = acc_full ? FULL_CNT : (acc_cnt_reg + {{(CW-1){1'b0}}, pop});
  assign acc_we   = pop & (~load | acc_full);
  assign acc_widx = load ? '0 : acc_cnt_reg;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign load_word[gi*DSIZE +: DSIZE] =
        (CW'(gi) < acc_cnt_reg)                ? acc_reg[gi] :
        ((CW'(gi) == acc_cnt_reg) && pop)      ? rdata       : '0;
    assign load_keep[gi] = (CW'(gi) < load_n);
  end

  always_comb begin
    acc_cnt_next = acc_cnt_reg;
    if (load) begin
      acc_cnt_next = (acc_full && pop) ? CW'(1) : '0;
    end else if (pop) begin
      acc_cnt_next = acc_cnt_reg + CW'(1);
    end
  end

  // A flush that cannot be served now is remembered until a beat carries it;
  // with nothing buffered and nothing arriving it is simply dropped.
  always_comb begin
    flush_pend_next = flush_pend_reg;
    if (load) begin
      flush_pend_next = 1'b0;
    end else if (flush && (!acc_empty || pop)) begin
      flush_pend_next = 1'b1;
    end else if (acc_empty) begin
      flush_pend_next = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_reg        <= 1'b0;
      acc_cnt_reg    <= '0;
      flush_pend_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      for (int i = 0; i < RATIO; i++) begin
        acc_reg[i] <= '0;
      end
    end else begin
      run_reg        <= 1'b1;
      acc_cnt_reg    <= acc_cnt_next;
      flush_pend_reg <= flush_pend_next;
      for (int i = 0; i < RATIO; i++) begin
        if (acc_we && (acc_widx == CW'(i))) begin
          acc_reg[i] <= rdata;
        end
      end
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= load_word;
        out_keep_reg  <= load_keep;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_idle
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        idle_reg <= '0;
      end else if (pop || load || acc_empty) begin
        idle_reg <= '0;
      end else if (idle_reg != IDLE_MAX) begin
        idle_reg <= idle_reg + IW'(1);
      end
    end

    assign timeout_hit = (idle_reg == IDLE_MAX);
  end else begin : g_no_idle
    assign idle_reg    = '0;
    assign timeout_hit = 1'b0;
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_keep  = out_keep_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: show-ahead FIFO model, beat scoreboard,
// a table of stream/flush/timeout cases and hand-written multi-cycle sequences.
module tb_fifo_rd_packer;

  localparam int DSIZE   = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 8;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep)
  );

  typedef struct { logic [31:0] data; logic [3:0] keep; } beat_t;
  typedef struct {
    int         n;
    logic [7:0] base;
    bit         use_flush;
    int         exp_beats;
    logic [3:0] exp_last_keep;
  } vec_t;

  beat_t      exp_q[$];
  logic [7:0] fifo_q[$];
  int         pop_cyc_q[$];
  int         beat_cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] last_keep;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(logic [7:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic expect_beat(logic [31:0] d, logic [3:0] k);
    beat_t b;
    b.data = d;
    b.keep = k;
    exp_q.push_back(b);
  endtask

  // One clock: sample at the falling edge, retire FIFO pop just after the rising edge.
  task automatic tick();
    beat_t e;
    bit    pop_seen;
    @(negedge rclk);
    cyc++;
    pop_seen = rinc;
    if (pop_seen) begin
      pop_cyc_q.push_back(cyc);
      check("rinc_vs_empty", rempty, 1'b0);
    end
    if (out_valid && out_ready) begin
      beat_cyc_q.push_back(cyc);
      last_keep = out_keep;
      $display("beat cyc=%0d data=%h keep=%h", cyc, out_data, out_keep);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data=%h keep=%h, expected no beat", out_data, out_keep);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_keep", out_keep, e.keep);
      end
    end
    @(posedge rclk);
    #1;
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_fifo_empty(string name, int budget);
    int n = 0;
    while (fifo_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, fifo_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] acc;
    logic [31:0] held;
    int          lane;
    int          base_beats;
    int          base_pops;
    int          rel_cyc;

    vecs[0] = '{3, 8'h10, 1'b1, 1, 4'h7};
    vecs[1] = '{5, 8'h20, 1'b1, 2, 4'h1};
    vecs[2] = '{6, 8'h30, 1'b0, 2, 4'h3};
    vecs[3] = '{4, 8'h50, 1'b1, 1, 4'hF};
    vecs[4] = '{1, 8'h70, 1'b0, 1, 4'h1};
    vecs[5] = '{7, 8'h80, 1'b1, 2, 4'h7};

    // Reset state with FIFO preloaded 01..08
    rrst_n    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    refresh();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_keep", out_keep, 4'h0);
    check("rst_rinc", rinc, 1'b0);

    // Test 1: streaming two full beats
    pop_cyc_q.delete();
    beat_cyc_q.delete();
    rrst_n = 1'b1;
    #1;
    check("t1_rinc_at_release", rinc, 1'b0);
    rel_cyc = cyc + 1;
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    drain("t1_drain", 30);
    check("t1_pop_count", pop_cyc_q.size(), 8);
    check("t1_first_pop_cyc", pop_cyc_q[0], rel_cyc + 1);
    check("t1_pops_consecutive", pop_cyc_q[7] - pop_cyc_q[0], 7);
    check("t1_first_valid_lat", beat_cyc_q[0], pop_cyc_q[3] + 1);
    check("t1_second_valid_lat", beat_cyc_q[1], pop_cyc_q[7] + 1);

    // Table of stream lengths with explicit flush or idle timeout
    for (int v = 0; v < 6; v++) begin
      base_beats = beat_cyc_q.size();
      acc  = '0;
      lane = 0;
      for (int i = 0; i < vecs[v].n; i++) begin
        push_word(vecs[v].base + 8'(i));
        acc[lane*8 +: 8] = vecs[v].base + 8'(i);
        lane++;
        if (lane == RATIO || i == vecs[v].n - 1) begin
          expect_beat(acc, 4'((1 << lane) - 1));
          acc  = '0;
          lane = 0;
        end
      end
      wait_fifo_empty("tbl_fifo_empty", 40);
      if (vecs[v].use_flush) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      drain("tbl_drain", 30);
      repeat (3) tick();
      check("tbl_beat_count", beat_cyc_q.size() - base_beats, vecs[v].exp_beats);
      check("tbl_last_keep", last_keep, vecs[v].exp_last_keep);
    end

    // Test 2: partial beat from idle timeout, nothing after
    push_word(8'hAA);
    push_word(8'hBB);
    expect_beat(32'h0000BBAA, 4'h3);
    drain("t2_drain", 40);
    check("t2_timeout_latency", beat_cyc_q[beat_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-1], 10);
    check("t2_keep", last_keep, 4'h3);
    base_beats = beat_cyc_q.size();
    repeat (20) tick();
    check("t2_no_extra_beat", beat_cyc_q.size() - base_beats, 0);

    // Test 3: flush while output is blocked is held until a beat can load
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(8'hC0 + 8'(i));
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    expect_beat(32'hC4C3C2C1, 4'hF);
    expect_beat(32'h00332211, 4'h7);
    wait_fifo_empty("t3_fifo_empty", 20);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    check("t3_held_valid", out_valid, 1'b1);
    check("t3_held_data", out_data, 32'hC4C3C2C1);
    out_ready = 1'b1;
    drain("t3_drain", 10);
    check("t3_pend_beat_gap", beat_cyc_q[beat_cyc_q.size()-1] - beat_cyc_q[beat_cyc_q.size()-2], 1);

    // Test 4: backpressure with 12 words queued
    out_ready = 1'b0;
    base_pops = pop_cyc_q.size();
    for (int i = 0; i < 12; i++) push_word(8'h40 + 8'(i));
    expect_beat(32'h43424140, 4'hF);
    expect_beat(32'h47464544, 4'hF);
    expect_beat(32'h4B4A4948, 4'hF);
    repeat (12) tick();
    held = out_data;
    repeat (8) tick();
    check("t4_pop_count", pop_cyc_q.size() - base_pops, 8);
    check("t4_rinc_blocked", rinc, 1'b0);
    check("t4_out_valid_held", out_valid, 1'b1);
    check("t4_out_data_stable", out_data, held);
    check("t4_out_keep_held", out_keep, 4'hF);
    out_ready = 1'b1;
    drain("t4_drain", 30);
    check("t4_fifo_empty", fifo_q.size(), 0);

    // Test 5: flush in the same cycle as the second pop
    repeat (3) tick();
    push_word(8'hA5);
    tick();
    push_word(8'h5A);
    flush = 1'b1;
    expect_beat(32'h00005AA5, 4'h3);
    tick();
    flush = 1'b0;
    drain("t5_drain", 5);
    check("t5_beat_latency", beat_cyc_q[beat_cyc_q.size()-1], pop_cyc_q[pop_cyc_q.size()-1] + 1);

    // Test 6: asynchronous reset with acc_cnt=2 and a held beat
    repeat (3) tick();
    out_ready = 1'b0;
    base_pops = pop_cyc_q.size();
    for (int i = 0; i < 6; i++) push_word(8'h90 + 8'(i));
    for (int n = 0; n < 20 && (pop_cyc_q.size() - base_pops) < 6; n++) tick();
    check("t6_pops_before_reset", pop_cyc_q.size() - base_pops, 6);
    check("t6_valid_before_reset", out_valid, 1'b1);
    #2;
    rrst_n = 1'b0;
    #1;
    check("t6_async_out_valid", out_valid, 1'b0);
    check("t6_async_out_data", out_data, 32'h0);
    check("t6_async_out_keep", out_keep, 4'h0);
    check("t6_async_rinc", rinc, 1'b0);
    fifo_q.delete();
    exp_q.delete();
    refresh();
    repeat (2) tick();
    for (int i = 1; i <= 4; i++) push_word(8'h60 + 8'(i));
    rrst_n    = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_rinc_at_release", rinc, 1'b0);
    tick();
    check("t6_rinc_after_edge", rinc, 1'b1);
    expect_beat(32'h64636261, 4'hF);
    drain("t6_drain", 20);

    repeat (5) tick();
    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
